divclock_tick_counter: RTL and testbench
========================================

Name: divclock_tick_counter

Overview:
- Receiving end of the ripple clock divider's `divclock[2:0]` outputs.
- Treats the divided bits as asynchronous data, not as clocks. Brings them into the `clk` domain and turns rising edges of a selected bit into single-cycle ticks.
- Counts those ticks modulo MOD under a small run/pause/idle state machine.
- Provides the synchronous T-style counter that the display and timing logic consume, instead of clocking logic directly from divider outputs.

Parameters:
- MOD, 10, counter modulus; count runs 0..MOD-1; legal range 1..2^W.
- W, 4, width of count output; must satisfy MOD <= 2^W.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous reset, active-high.
- divclock  in  3  divided-clock bits from the divider; asynchronous to clk.
- sel  in  2  source select: 0→divclock[0], 1→divclock[1], 2 and 3→divclock[2].
- en  in  1  run enable.
- clear  in  1  synchronous counter clear; returns the block to IDLE.
- tick  out  1  one-cycle pulse per rising edge of the selected bit, counted or not.
- count  out  W  current count.
- tc  out  1  one-cycle pulse on wrap MOD-1→0.
- running  out  1  high while in RUN.

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - tick=0, count=0, tc=0, running=0.
  - state=IDLE.
  - All synchronizer stages and edge history are set to 0.
  - sel_q=0.
- Synchronizer:
  - Each divclock bit passes through 2 flops (s1, s2).
  - An edge-history flop (s3) holds the previous s2 of the selected bit.
- Edge condition: `edge = s2[sel] & ~s3`, evaluated only when sel == sel_q.
- Latency: divclock[sel] rises and is first captured at clk edge N. Then s2=1 at edge N+1, and tick, count and tc update at edge N+2. Outputs are visible in the cycle after edge N+2, so there are 3 clk edges from capture to visible output.
- Pulse width: tick and tc are registered and are high for exactly 1 cycle per event.
- Source switch:
  - When sel != sel_q, s3 is loaded with s2 of the new bit and tick is suppressed that cycle.
  - sel_q is then updated.
  - Switching to a bit that is already high produces no spurious tick.
- States:
  - IDLE: count held at 0; ticks still pulse but are not counted. en=1 → RUN.
  - RUN: running=1; each edge increments count. en=0 → PAUSE. clear=1 → IDLE.
  - PAUSE: count held. en=1 → RUN. clear=1 → IDLE.
- Priority, highest first: rst > clear > edge-count > hold.
  - clear in the same cycle as an edge: count=0, tc=0, tick still pulses.
- Wrap: an edge at count=MOD-1 sets count=0 and tc=1 on the same edge. No other value increment ever asserts tc.
- MOD=1: count stays 0 and tc pulses on every counted edge.
- Enable timing: en rising in the same cycle as an edge while in IDLE or PAUSE → that edge is not counted; counting starts with the next edge.
- Reset mid-operation: all state returns to reset values at the next clk edge. The first edge after reset needs a full 0→1 transition seen by the synchronizer.
- Edge rate: edges faster than one per 3 clk cycles are not required to be counted. The divider guarantees ≥2 clk cycles per level.

Decomposition:
- Shared package divclock_pkg:
  - state enum {IDLE, RUN, PAUSE}, 2 bits.
  - SEL_BIT0/1/2 localparams.
  - Synchronizer depth constant (2).
- Sub-module edge_sync: one 2-flop synchronizer plus previous-value flop, with load-history input for source switching. The top level instantiates it per divclock bit, or once behind the mux.

Test Plan:
- Reset, then en=1, sel=0, divclock[0] toggling every 4 cycles → first tick 3 edges after capture; count 1,2,…,9,0; tc high exactly on the 9→0 cycle.
- In RUN at count=5, drop en for 3 edges, then raise en → count stays 5 across the paused edges, then resumes 6,7; running low during PAUSE.
- clear asserted on the same cycle as an edge at count=7 → count=0, state IDLE, tick=1, tc=0; subsequent edges do not count until en=1.
- Hold divclock[2]=1, divclock[0]=0, switch sel 0→2 → no tick that cycle or after; first tick only after divclock[2] falls and rises again.
- Set MOD=1 → every counted edge gives count=0, tc=1, tick=1 together.
- Assert rst mid-count at count=4 → next cycle count=0, running=0, tick=0; a divclock bit already high at reset release gives no tick until a new rising edge.

Source files
------------

// File: rtl/divclock_pkg.sv
// Shared types and constants for the divided-clock tick counter.
// Holds the FSM state encoding, source-select codes and synchronizer depth.
package divclock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_BIT0 = 2'd0;
  localparam logic [1:0] SEL_BIT1 = 2'd1;
  localparam logic [1:0] SEL_BIT2 = 2'd2;

  localparam int SYNC_DEPTH = 2;

  // Codes 2 and 3 both pick the slowest divider bit.
  function automatic logic pick_bit(input logic [2:0] v, input logic [1:0] sel);
    case (sel)
      SEL_BIT0: return v[0];
      SEL_BIT1: return v[1];
      default:  return v[2];
    endcase
  endfunction

endpackage

// File: rtl/divclock_tick_counter_edge_sync.sv
// Two-flop synchronizer on every divider bit, then rising-edge detect on the
// selected bit against a history flop; history reloads on source switch or warm-up.
module divclock_tick_counter_edge_sync
  import divclock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] async_i,
  input  logic [1:0] sel_i,
  input  logic       hist_load_i,
  output logic       edge_o
);

  localparam int WARM = SYNC_DEPTH + 1;

  logic [SYNC_DEPTH-1:0][2:0] sync_q;
  logic                       hist_q;
  logic [1:0]                 warm_q;
  logic                       cur;
  logic                       warm;

  assign cur  = pick_bit(sync_q[SYNC_DEPTH-1], sel_i);
  // Until the synchronizer has flushed its reset zeros, a bit that was already
  // high would look like a rising edge; hold the history in load mode instead.
  assign warm = (warm_q != 2'(WARM));

  assign edge_o = cur & ~hist_q & ~hist_load_i & ~warm;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
      hist_q <= cur;
      if (warm) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/divclock_tick_counter.sv
// Counts rising edges of a selected divider bit, modulo MOD, in the clk domain.
// Tick/tc are registered single-cycle pulses; run/pause/idle FSM gates counting.
module divclock_tick_counter
  import divclock_pkg::*;
#(
  parameter int MOD = 10,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   divclock,
  input  logic [1:0]   sel,
  input  logic         en,
  input  logic         clear,
  output logic         tick,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         running
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  state_e       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         tick_q;
  logic [1:0]   sel_q;
  logic         edge_w;

  divclock_tick_counter_edge_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .async_i     (divclock),
    .sel_i       (sel),
    .hist_load_i (sel != sel_q),
    .edge_o      (edge_w)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (edge_w) begin
          if (count_q == LAST) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + W'(1);
          end
        end
        if (!en) state_d = PAUSE;
      end
      PAUSE: begin
        if (en) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    // Clear overrides any count or wrap from an edge in the same cycle.
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
      tc_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      tick_q  <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      tick_q  <= edge_w;
      sel_q   <= sel;
    end
  end

  assign tick    = tick_q;
  assign count   = count_q;
  assign tc      = tc_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_divclock_tick_counter.sv
module tb_divclock_tick_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] divclock;
  logic [1:0] sel;
  logic       en;
  logic       clear;

  logic       tick, tc, running;
  logic [3:0] count;
  logic       tick1, tc1, running1;
  logic [0:0] count1;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int ntick  = 0;

  typedef struct {
    int         due;
    logic [3:0] cnt;
    logic       tc;
    logic       run;
    logic       tc1;
  } exp_t;

  typedef struct {
    logic       en;
    int         en_off;
    logic       clr;
    int         ec;
    logic       etc;
    logic       erun;
    logic       etc1;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[$];

  divclock_tick_counter #(.MOD(10), .W(4)) dut (
    .clk(clk), .rst(rst), .divclock(divclock), .sel(sel), .en(en), .clear(clear),
    .tick(tick), .count(count), .tc(tc), .running(running)
  );

  divclock_tick_counter #(.MOD(1), .W(1)) dut1 (
    .clk(clk), .rst(rst), .divclock(divclock), .sel(sel), .en(en), .clear(clear),
    .tick(tick1), .count(count1), .tc(tc1), .running(running1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: every tick pops the expectation pushed when its edge was driven.
  exp_t e;
  always @(negedge clk) begin
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_tick due=%0d now=%0d", sbq[0].due, cyc);
      void'(sbq.pop_front());
    end
    if (tick1 !== tick) begin
      checks++;
      errors++;
      $display("FAIL tick_pair tick=%0b tick1=%0b", tick, tick1);
    end
    if ((tc && !tick) || (tc1 && !tick1)) begin
      checks++;
      errors++;
      $display("FAIL tc_without_tick tc=%0b tc1=%0b tick=%0b", tc, tc1, tick);
    end
    if (tick) begin
      ntick++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_tick cyc=%0d count=%0d got=1 want=0", cyc, count);
      end else begin
        e = sbq.pop_front();
        chk("tick_cycle", 32'(cyc), 32'(e.due));
        chk("count", 32'(count), 32'(e.cnt));
        chk("tc", 32'(tc), 32'(e.tc));
        chk("running", 32'(running), 32'(e.run));
        chk("count_mod1", 32'(count1), 32'(0));
        chk("tc_mod1", 32'(tc1), 32'(e.tc1));
        chk("running_mod1", 32'(running1), 32'(e.run));
      end
    end
  end

  function automatic vec_t mk(input logic en_v, input int off, input logic clr_v, input int ec,
                              input logic etc, input logic erun, input logic etc1);
    vec_t v;
    v.en = en_v; v.en_off = off; v.clr = clr_v; v.ec = ec;
    v.etc = etc; v.erun = erun; v.etc1 = etc1;
    return v;
  endfunction

  function automatic exp_t mkexp(input int due, input int ec, input logic etc,
                                 input logic erun, input logic etc1);
    exp_t x;
    x.due = due; x.cnt = 4'(ec); x.tc = etc; x.run = erun; x.tc1 = etc1;
    return x;
  endfunction

  // One 8-cycle divider period on bit b: high 4, low 4. en changes at en_off,
  // clear (if requested) is a one-cycle pulse landing on the edge-detect cycle.
  task automatic period(input int b, input vec_t v);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        divclock[b] = 1'b1;
        sbq.push_back(mkexp(cyc + 3, v.ec, v.etc, v.erun, v.etc1));
      end
      if (k == v.en_off) en = v.en;
      if (k == 2) clear = v.clr;
      if (k == 3) clear = 1'b0;
      if (k == 4) divclock[b] = 1'b0;
    end
  endtask

  int n0;

  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; sel = 2'd0; divclock = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_tick", 32'(tick), 32'(0));
    chk("reset_count", 32'(count), 32'(0));
    chk("reset_tc", 32'(tc), 32'(0));
    chk("reset_running", 32'(running), 32'(0));
    chk("reset_running_mod1", 32'(running1), 32'(0));
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 1; i <= 9; i++) vt.push_back(mk(1'b1, 0, 1'b0, i, 1'b0, 1'b1, 1'b1));
    vt.push_back(mk(1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 1'b1));
    for (int i = 1; i <= 5; i++) vt.push_back(mk(1'b1, 0, 1'b0, i, 1'b0, 1'b1, 1'b1));
    repeat (3) vt.push_back(mk(1'b0, 0, 1'b0, 5, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 0, 1'b0, 6, 1'b0, 1'b1, 1'b1));
    vt.push_back(mk(1'b1, 0, 1'b0, 7, 1'b0, 1'b1, 1'b1));
    vt.push_back(mk(1'b0, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0));
    repeat (2) vt.push_back(mk(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
    for (int i = 1; i <= 9; i++) vt.push_back(mk(1'b1, 0, 1'b0, i, 1'b0, 1'b1, 1'b1));
    vt.push_back(mk(1'b0, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 2, 1'b0, 0, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(1'b1, 0, 1'b0, 1, 1'b0, 1'b1, 1'b1));
    vt.push_back(mk(1'b0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0));
    vt.push_back(mk(1'b1, 2, 1'b0, 1, 1'b0, 1'b1, 1'b0));
    vt.push_back(mk(1'b1, 0, 1'b0, 2, 1'b0, 1'b1, 1'b1));

    for (int i = 0; i < vt.size(); i++) period(0, vt[i]);

    // Switch to a source that is already high: no tick until it falls and rises.
    @(negedge clk); divclock[2] = 1'b1;
    repeat (5) @(negedge clk);
    n0 = ntick;
    sel = 2'd2;
    repeat (12) @(negedge clk);
    chk("switch_no_tick", 32'(ntick - n0), 32'(0));
    chk("switch_count_held", 32'(count), 32'(2));
    divclock[2] = 1'b0;
    repeat (4) @(negedge clk);
    divclock[2] = 1'b1;
    sbq.push_back(mkexp(cyc + 3, 3, 1'b0, 1'b1, 1'b1));
    repeat (4) @(negedge clk);
    divclock[2] = 1'b0;
    repeat (4) @(negedge clk);
    sel = 2'd0;
    repeat (4) @(negedge clk);

    // Reset mid-count with the selected bit high across reset release.
    period(0, mk(1'b1, 0, 1'b0, 4, 1'b0, 1'b1, 1'b1));
    @(negedge clk); divclock[0] = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_running", 32'(running), 32'(0));
    chk("midrst_tick", 32'(tick), 32'(0));
    chk("midrst_tc", 32'(tc), 32'(0));
    n0 = ntick;
    repeat (10) @(negedge clk);
    chk("midrst_no_tick", 32'(ntick - n0), 32'(0));
    divclock[0] = 1'b0;
    repeat (4) @(negedge clk);
    divclock[0] = 1'b1;
    sbq.push_back(mkexp(cyc + 3, 1, 1'b0, 1'b1, 1'b1));
    repeat (4) @(negedge clk);
    divclock[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
